// File: rtl/rr_stream_mux.sv
// M-input registered stream mux: round-robin or fixed-select arbitration with
// packet locking on in_last, followed by one pipeline register stage.
module rr_stream_mux #(
   parameter int N  = 64,
   parameter int M  = 4,
   parameter int CW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mode,
   input  logic [CW-1:0]   sel,
   input  logic [M-1:0]    in_valid,
   input  logic [M-1:0]    in_last,
   input  logic [M*N-1:0]  in_data,
   output logic [M-1:0]    in_ready,
   output logic            out_valid,
   output logic [N-1:0]    out_data,
   output logic [CW-1:0]   out_chan,
   output logic            out_last,
   input  logic            out_ready,
   output logic            dbg_locked,
   output logic [CW-1:0]   dbg_ptr
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   state_e          state_q;
   logic [CW-1:0]   lock_q;
   logic            lock_rr_q;
   logic [CW-1:0]   ptr_q;
   logic            out_valid_q;
   logic [N-1:0]    out_data_q;
   logic [CW-1:0]   out_chan_q;
   logic            out_last_q;

   logic            load;
   logic [CW-1:0]   grant;
   logic            grant_valid;
   logic            xfer;
   logic            xfer_last;
   logic [N-1:0]    xfer_data;
   logic [CW-1:0]   ptr_d;
   logic            ptr_adv;
   logic            lock_valid;
   logic            sel_valid;
   int              rr_idx;

   // Gating with rst_n keeps in_ready low while the block is held in reset.
   assign load = rst_n && (!out_valid_q || out_ready);

   always_comb begin
      lock_valid = 1'b0;
      sel_valid  = 1'b0;
      for (int k = 0; k < M; k++) begin
         if (lock_q == CW'(k)) lock_valid = in_valid[k];
         if (sel == CW'(k))    sel_valid  = in_valid[k];
      end
   end

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      rr_idx      = 0;
      if (state_q == LOCKED) begin
         grant       = lock_q;
         grant_valid = lock_valid;
      end else if (mode) begin
         grant       = sel;
         grant_valid = sel_valid;
      end else begin
         // Scan from ptr upward with wrap; the first valid channel wins.
         for (int i = 0; i < M; i++) begin
            rr_idx = int'(ptr_q) + i;
            if (rr_idx >= M) rr_idx = rr_idx - M;
            if (!grant_valid && in_valid[rr_idx]) begin
               grant       = CW'(rr_idx);
               grant_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready  = '0;
      xfer_data = '0;
      xfer_last = 1'b0;
      for (int k = 0; k < M; k++) begin
         in_ready[k] = load && grant_valid && (grant == CW'(k));
         if (grant == CW'(k)) begin
            xfer_data = in_data[k*N +: N];
            xfer_last = in_last[k];
         end
      end
   end

   assign xfer    = load && grant_valid;
   assign ptr_d   = (int'(grant) + 1 == M) ? '0 : grant + CW'(1);
   // Only packets that started under round-robin move the pointer.
   assign ptr_adv = xfer_last &&
                    ((state_q == IDLE && !mode) || (state_q == LOCKED && lock_rr_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lock_q      <= '0;
         lock_rr_q   <= 1'b0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (load) begin
            out_valid_q <= xfer;
            if (xfer) begin
               out_data_q <= xfer_data;
               out_chan_q <= grant;
               out_last_q <= xfer_last;
            end
         end
         if (xfer) begin
            case (state_q)
               IDLE: begin
                  if (!xfer_last) begin
                     state_q   <= LOCKED;
                     lock_q    <= grant;
                     lock_rr_q <= !mode;
                  end
               end
               LOCKED: begin
                  if (xfer_last) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
            if (ptr_adv) ptr_q <= ptr_d;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_chan   = out_chan_q;
   assign out_last   = out_last_q;
   assign dbg_locked = (state_q == LOCKED);
   assign dbg_ptr    = ptr_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed stimulus with an expected-beat queue
// checked whenever the output handshake fires.
module tb_rr_stream_mux;
   localparam int N  = 8;
   localparam int M  = 4;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            mode = 1'b0;
   logic [CW-1:0]   sel = '0;
   logic [M-1:0]    in_valid = '0;
   logic [M-1:0]    in_last = '0;
   logic [M*N-1:0]  in_data = '0;
   logic [M-1:0]    in_ready;
   logic            out_valid;
   logic [N-1:0]    out_data;
   logic [CW-1:0]   out_chan;
   logic            out_last;
   logic            out_ready = 1'b0;
   logic            dbg_locked;
   logic [CW-1:0]   dbg_ptr;

   // Three-channel instance used for the out-of-range select case.
   logic [1:0]      b_sel = 2'd3;
   logic [2:0]      b_valid = '0;
   logic [2:0]      b_ready;
   logic            b_out_valid;
   logic [7:0]      b_out_data;
   logic [1:0]      b_out_chan;
   logic            b_out_last;
   logic            b_locked;
   logic [1:0]      b_ptr;

   logic [10:0]     exp_q[$];
   logic [10:0]     mon_e;
   int              n_vec = 0;
   int              n_err = 0;

   rr_stream_mux #(.N(N), .M(M), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_chan(out_chan), .out_last(out_last), .out_ready(out_ready),
      .dbg_locked(dbg_locked), .dbg_ptr(dbg_ptr)
   );

   rr_stream_mux #(.N(8), .M(3), .CW(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(1'b1), .sel(b_sel),
      .in_valid(b_valid), .in_last(3'b111), .in_data(24'h332211),
      .in_ready(b_ready), .out_valid(b_out_valid), .out_data(b_out_data),
      .out_chan(b_out_chan), .out_last(b_out_last), .out_ready(1'b1),
      .dbg_locked(b_locked), .dbg_ptr(b_ptr)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
      in_valid = v;
      in_last  = l;
      in_data  = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [1:0] ch, input logic last, input logic [7:0] d);
      exp_q.push_back({ch, last, d});
   endtask

   // Scoreboard: a beat is consumed at the next posedge when valid && ready.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(exp_q.size()), 64'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check("beat", {out_chan, out_last, out_data}, mon_e);
         end
      end
   end

   initial begin
      // Reset and idle
      in_valid = 4'hF;
      #1 rst_n = 1'b0;
      #2;
      check("rst_in_ready", in_ready, 4'b0000);
      check("rst_out_valid", out_valid, 1'b0);
      in_valid = '0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_valid", out_valid, 1'b0);
         check("idle_ready", in_ready, 4'b0000);
         check("idle_data", out_data, 8'h00);
         tick();
      end

      // Round-robin fairness
      out_ready = 1'b1;
      mode = 1'b0;
      for (int k = 0; k < 8; k++) push(2'(k % 4), 1'b1, 8'hA0 + 8'(k % 4));
      drive(4'b1111, 4'b1111, 32'hA3A2A1A0);
      @(negedge clk);
      check("rr_ready0", in_ready, 4'b0001);
      tick();
      repeat (7) tick();
      drive(4'b0000, 4'b0000, 32'h0);
      tick();
      tick();
      check("rr_ptr", dbg_ptr, 2'd0);

      // Packet lock on channel 1 while channel 2 waits
      push(2'd1, 1'b0, 8'hB0);
      push(2'd1, 1'b0, 8'hB1);
      push(2'd1, 1'b1, 8'hB2);
      push(2'd2, 1'b1, 8'hC0);
      drive(4'b0110, 4'b0100, 32'h00C0B000);
      @(negedge clk);
      check("lk_ready_a", in_ready, 4'b0010);
      tick();
      drive(4'b0110, 4'b0100, 32'h00C0B100);
      @(negedge clk);
      check("lk_ready_b", in_ready, 4'b0010);
      check("lk_state", dbg_locked, 1'b1);
      tick();
      drive(4'b0110, 4'b0110, 32'h00C0B200);
      @(negedge clk);
      check("lk_ready_c", in_ready, 4'b0010);
      tick();
      drive(4'b0100, 4'b0100, 32'h00C00000);
      @(negedge clk);
      check("lk_ptr", dbg_ptr, 2'd2);
      check("lk_unlocked", dbg_locked, 1'b0);
      check("lk_ready_ch2", in_ready, 4'b0100);
      tick();
      drive(4'b0000, 4'b0000, 32'h0);
      tick();
      tick();

      // Backpressure (ptr=3, so channel 0 is reached by wrapping)
      out_ready = 1'b0;
      push(2'd0, 1'b1, 8'hD0);
      drive(4'b0001, 4'b0001, 32'h000000D0);
      tick();
      in_data = 32'h000000D1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1'b1);
         check("bp_data", out_data, 8'hD0);
         check("bp_ready", in_ready, 4'b0000);
         tick();
      end
      out_ready = 1'b1;
      push(2'd0, 1'b1, 8'hD1);
      @(negedge clk);
      check("bp_release", in_ready, 4'b0001);
      tick();
      drive(4'b0000, 4'b0000, 32'h0);
      tick();
      tick();

      // Fixed select
      mode = 1'b1;
      sel = 2'd2;
      drive(4'b1011, 4'b1111, 32'hE3E2E1E0);
      @(negedge clk);
      check("fx_none", in_ready, 4'b0000);
      tick();
      @(negedge clk);
      check("fx_idle", out_valid, 1'b0);
      tick();
      drive(4'b1111, 4'b1111, 32'hE3E2E1E0);
      push(2'd2, 1'b1, 8'hE2);
      @(negedge clk);
      check("fx_grant", in_ready, 4'b0100);
      tick();
      drive(4'b0000, 4'b0000, 32'h0);
      tick();
      check("fx_ptr", dbg_ptr, 2'd1);

      // Mode/sel changes mid-packet are ignored until the last beat
      push(2'd2, 1'b0, 8'hF0);
      drive(4'b0111, 4'b0011, 32'h00F0A1A0);
      tick();
      mode = 1'b0;
      sel = 2'd0;
      push(2'd2, 1'b1, 8'hF1);
      drive(4'b0111, 4'b0111, 32'h00F1A1A0);
      @(negedge clk);
      check("mid_ready", in_ready, 4'b0100);
      tick();
      push(2'd1, 1'b1, 8'hA1);
      drive(4'b0011, 4'b0011, 32'h0000A1A0);
      @(negedge clk);
      check("mid_ptr", dbg_ptr, 2'd1);
      check("mid_rr", in_ready, 4'b0010);
      tick();
      drive(4'b0000, 4'b0000, 32'h0);
      tick();
      tick();

      // Select beyond M on the three-channel instance
      b_valid = 3'b111;
      b_sel = 2'd3;
      @(negedge clk);
      check("m3_sel_oob", b_ready, 3'b000);
      b_sel = 2'd2;
      #1;
      check("m3_sel2", b_ready, 3'b100);
      b_valid = 3'b000;
      tick();

      // Asynchronous reset mid-packet (ptr=2, so channel 0 found by wrap)
      out_ready = 1'b0;
      drive(4'b0001, 4'b0000, 32'h000000C7);
      tick();
      check("ar_locked", dbg_locked, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", out_valid, 1'b0);
      check("ar_state", dbg_locked, 1'b0);
      check("ar_ready", in_ready, 4'b0000);
      drive(4'b0000, 4'b0000, 32'h0);
      tick();
      rst_n = 1'b1;
      check("ar_ptr", dbg_ptr, 2'd0);
      out_ready = 1'b1;
      push(2'd3, 1'b1, 8'h5A);
      drive(4'b1000, 4'b1000, 32'h5A000000);
      @(negedge clk);
      check("ar_grant3", in_ready, 4'b1000);
      tick();
      drive(4'b0000, 4'b0000, 32'h0);
      tick();

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("drain", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
